rt_pixel_dispatcher: RTL and testbench

- Raster scheduler that sits directly upstream of the RT core.
- Walks every (X, Y) of the frame, issues one pixel request at a time to the RT core, and collects the 4-bit shade it returns.
- Packs four shades into one 16-bit word and writes it to the frame-buffer write port with a req/ack handshake.
- Signals frame completion and optionally restarts the scan for continuous rendering.

---
 rtl/rt_pkg.sv | 22 ++
 rtl/rt_pixel_packer.sv | 76 +++++++
 rtl/rt_pixel_dispatcher.sv | 148 ++++++++++++++
 tb/tb_rt_pixel_dispatcher.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// Shared raster constants, pixel/coordinate types and the dispatcher state encoding.
// The RT core, the video output and the pixel dispatcher all import this package.
package rt_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PIXEL_W  = 4;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [9:0]         coord_x_t;
    typedef logic [8:0]         coord_y_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_WRITE,
        S_ADVANCE
    } disp_state_e;

endpackage

// File: rtl/rt_pixel_packer.sv
// Packs PACK shades into one frame-buffer word and runs the FB req/ack handshake.
// The word address advances by one per acked word and is cleared at frame start.
module rt_pixel_packer #(
    parameter int PIX_W  = 4,
    parameter int PACK   = 4,
    parameter int ADDR_W = 17
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    capture,
    input  logic [PIX_W-1:0]        pixel,
    input  logic                    fb_ack,
    output logic                    last_slot,
    output logic                    word_done,
    output logic                    fb_we,
    output logic [ADDR_W-1:0]       fb_addr,
    output logic [PACK*PIX_W-1:0]   fb_data
);

    localparam int                IDX_W    = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PACK - 1);

    logic [IDX_W-1:0]        pack_q, pack_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [PACK*PIX_W-1:0]   data_q, data_d;

    // An ack only counts while a write is actually pending.
    assign word_done = we_q & fb_ack;
    assign last_slot = (pack_q == IDX_LAST);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        pack_d = pack_q;
        we_d   = we_q;
        addr_d = addr_q;
        data_d = data_q;
        if (clear) begin
            pack_d = '0;
            addr_d = '0;
            we_d   = 1'b0;
        end else if (capture) begin
            data_d[pack_q*PIX_W +: PIX_W] = pixel;
            if (pack_q == IDX_LAST) begin
                we_d = 1'b1;
            end else begin
                pack_d = pack_q + IDX_W'(1);
            end
        end else if (word_done) begin
            we_d   = 1'b0;
            pack_d = '0;
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            pack_q <= pack_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign fb_we   = we_q;
    assign fb_addr = addr_q;
    assign fb_data = data_q;

endmodule

// File: rtl/rt_pixel_dispatcher.sv
// Raster scheduler upstream of the RT core: walks every (X, Y), issues one request
// per pixel, and hands the returned shades to the packer for frame-buffer writes.
module rt_pixel_dispatcher
    import rt_pkg::*;
#(
    parameter int H_RES  = SCREEN_W,
    parameter int V_RES  = SCREEN_H,
    parameter int PIX_W  = 4,
    parameter int PACK   = 4,
    parameter int ADDR_W = 17
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    START,
    input  logic                    CONTINUOUS,
    input  logic                    RT_READY,
    input  logic [PIX_W-1:0]        RT_PIXEL,
    output logic                    RT_ENABLE,
    output logic [9:0]              RT_X,
    output logic [8:0]              RT_Y,
    output logic                    FB_WE,
    output logic [ADDR_W-1:0]       FB_ADDR,
    output logic [PACK*PIX_W-1:0]   FB_DATA,
    input  logic                    FB_ACK,
    output logic                    BUSY,
    output logic                    FRAME_DONE,
    output logic [15:0]             FRAME_COUNT
);

    localparam coord_x_t X_LAST = coord_x_t'(H_RES - 1);
    localparam coord_y_t Y_LAST = coord_y_t'(V_RES - 1);

    disp_state_e state_q, state_d;
    coord_x_t    x_q, x_d;
    coord_y_t    y_q, y_d;
    logic        rt_enable_q, rt_enable_d;
    logic        frame_done_q, frame_done_d;
    logic        busy_q, busy_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic pk_clear, pk_capture, pk_last, pk_word_done;

    rt_pixel_packer #(
        .PIX_W  (PIX_W),
        .PACK   (PACK),
        .ADDR_W (ADDR_W)
    ) u_packer (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .clear     (pk_clear),
        .capture   (pk_capture),
        .pixel     (RT_PIXEL),
        .fb_ack    (FB_ACK),
        .last_slot (pk_last),
        .word_done (pk_word_done),
        .fb_we     (FB_WE),
        .fb_addr   (FB_ADDR),
        .fb_data   (FB_DATA)
    );

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        rt_enable_d   = 1'b0;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        pk_clear      = 1'b0;
        pk_capture    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START || CONTINUOUS) begin
                    x_d      = '0;
                    y_d      = '0;
                    pk_clear = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (RT_READY) begin
                    rt_enable_d = 1'b1;
                    state_d     = S_WAIT_BUSY;
                end
            end
            // READY may still read high for a cycle after the request; only its fall
            // proves the core took the job, so completion is looked for after that.
            S_WAIT_BUSY: begin
                if (!RT_READY) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (RT_READY) begin
                    pk_capture = 1'b1;
                    state_d    = pk_last ? S_WRITE : S_ADVANCE;
                end
            end
            S_WRITE: begin
                if (pk_word_done) state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                state_d = S_ISSUE;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d           = '0;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                        pk_clear      = 1'b1;
                        if (!CONTINUOUS) state_d = S_IDLE;
                    end else begin
                        y_d = y_q + coord_y_t'(1);
                    end
                end else begin
                    x_d = x_q + coord_x_t'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            rt_enable_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            rt_enable_q   <= rt_enable_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign RT_ENABLE   = rt_enable_q;
    assign RT_X        = x_q;
    assign RT_Y        = y_q;
    assign BUSY        = busy_q;
    assign FRAME_DONE  = frame_done_q;
    assign FRAME_COUNT = frame_count_q;

endmodule

// File: tb/tb_rt_pixel_dispatcher.sv
// Directed bench for rt_pixel_dispatcher on an 8x2 frame with a behavioural RT core
// that returns shade = X and a frame-buffer port with programmable ack stalls.
module tb_rt_pixel_dispatcher;

    localparam int H     = 8;
    localparam int V     = 2;
    localparam int STALL = 7;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic        CONTINUOUS = 1'b0;
    logic        RT_READY = 1'b1;
    logic [3:0]  RT_PIXEL = 4'h0;
    logic        FB_ACK = 1'b1;
    logic        RT_ENABLE;
    logic [9:0]  RT_X;
    logic [8:0]  RT_Y;
    logic        FB_WE;
    logic [16:0] FB_ADDR;
    logic [15:0] FB_DATA;
    logic        BUSY;
    logic        FRAME_DONE;
    logic [15:0] FRAME_COUNT;

    rt_pixel_dispatcher #(
        .H_RES (H), .V_RES (V), .PIX_W (4), .PACK (4), .ADDR_W (17)
    ) dut (
        .CLK (CLK), .RESET_N (RESET_N), .START (START), .CONTINUOUS (CONTINUOUS),
        .RT_READY (RT_READY), .RT_PIXEL (RT_PIXEL), .RT_ENABLE (RT_ENABLE),
        .RT_X (RT_X), .RT_Y (RT_Y), .FB_WE (FB_WE), .FB_ADDR (FB_ADDR),
        .FB_DATA (FB_DATA), .FB_ACK (FB_ACK), .BUSY (BUSY),
        .FRAME_DONE (FRAME_DONE), .FRAME_COUNT (FRAME_COUNT)
    );

    always #5 CLK = ~CLK;

    int tests_run = 0;
    int tests_failed = 0;

    // RT core model state
    int          busy_cycles = 2;
    bit          rt_busy = 1'b0;
    int          rt_cnt = 0;
    logic [9:0]  rt_x_lat = '0;
    int          enable_pulses = 0;
    int          rt_bad = 0;
    int          coord_bad = 0;
    int          exp_x = 0;
    int          exp_y = 0;

    // Frame-buffer side state
    int          word_cnt = 0;
    logic [16:0] log_addr [64];
    logic [15:0] log_data [64];
    int          stall_word = -1;
    int          stall_left = 0;
    int          stall_seen = 0;
    int          stall_bad = 0;
    logic [16:0] stall_addr = '0;
    logic [15:0] stall_data = '0;

    // Frame-done / busy monitors
    int          done_cnt = 0;
    int          done_bad = 0;
    bit          done_prev = 1'b0;
    bit          expect_busy = 1'b0;
    int          busy_gap = 0;

    function automatic logic [15:0] exp_word(input int w);
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[k*4 +: 4] = 4'((w*4 + k) % H);
        return v;
    endfunction

    // RT core: stale READY for one cycle after the accepted request, then low for
    // busy_cycles, then READY high with shade = X of the request.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            rt_busy  = 1'b0;
            rt_cnt   = 0;
            RT_READY = 1'b1;
        end else begin
            if (RT_ENABLE) enable_pulses++;
            if (rt_busy) begin
                if (RT_ENABLE) rt_bad++;
                if (RT_X !== rt_x_lat) rt_bad++;
                rt_cnt++;
                if (rt_cnt == 1) begin
                    RT_READY = 1'b1;
                end else if (rt_cnt <= 1 + busy_cycles) begin
                    RT_READY = 1'b0;
                end else begin
                    RT_READY = 1'b1;
                    RT_PIXEL = rt_x_lat[3:0];
                    rt_busy  = 1'b0;
                end
            end else if (RT_ENABLE) begin
                if (RT_X !== 10'(exp_x) || RT_Y !== 9'(exp_y)) coord_bad++;
                rt_busy  = 1'b1;
                rt_cnt   = 0;
                rt_x_lat = RT_X;
                if (exp_x == H - 1) begin
                    exp_x = 0;
                    exp_y = (exp_y == V - 1) ? 0 : exp_y + 1;
                end else begin
                    exp_x++;
                end
            end
        end
    end

    // Frame-buffer port: acks immediately except for the programmed stall word.
    always @(negedge CLK) begin
        if (RESET_N && FB_WE) begin
            if (word_cnt == stall_word && stall_left > 0) begin
                if (stall_left == STALL) begin
                    stall_addr = FB_ADDR;
                    stall_data = FB_DATA;
                end
                if (FB_ADDR !== stall_addr || FB_DATA !== stall_data || RT_ENABLE !== 1'b0) stall_bad++;
                stall_left--;
                stall_seen++;
                FB_ACK = 1'b0;
            end else begin
                FB_ACK = 1'b1;
                if (word_cnt < 64) begin
                    log_addr[word_cnt] = FB_ADDR;
                    log_data[word_cnt] = FB_DATA;
                end
                word_cnt++;
            end
        end else begin
            FB_ACK = 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (FRAME_DONE) begin
            done_cnt++;
            if (done_prev) done_bad++;
        end
        done_prev = FRAME_DONE;
        if (expect_busy && !BUSY) busy_gap++;
    end

    task automatic clear_logs();
        word_cnt      = 0;
        done_cnt      = 0;
        done_bad      = 0;
        enable_pulses = 0;
        rt_bad        = 0;
        coord_bad     = 0;
        exp_x         = 0;
        exp_y         = 0;
        stall_word    = -1;
        stall_left    = 0;
        stall_seen    = 0;
        stall_bad     = 0;
        busy_gap      = 0;
        expect_busy   = 1'b0;
        busy_cycles   = 2;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        #1 RESET_N = 1'b0;
        @(negedge CLK);
        #2 RESET_N = 1'b1;
        clear_logs();
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done(input int n, input bit need_idle, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            #1;
            if (done_cnt >= n && (!need_idle || !BUSY)) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_enables(input int n, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            #1;
            if (enable_pulses >= n) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        tests_run++; if (RT_ENABLE !== 1'b0) begin tests_failed++; $display("FAIL reset_rt_enable: got %b expected 0", RT_ENABLE); end
        tests_run++; if (FB_WE !== 1'b0) begin tests_failed++; $display("FAIL reset_fb_we: got %b expected 0", FB_WE); end
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        tests_run++; if (FRAME_DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done: got %b expected 0", FRAME_DONE); end
        tests_run++; if (RT_X !== 10'd0 || RT_Y !== 9'd0) begin tests_failed++; $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", RT_X, RT_Y); end
        tests_run++; if (FB_ADDR !== 17'd0) begin tests_failed++; $display("FAIL reset_fb_addr: got %h expected 0", FB_ADDR); end
        tests_run++; if (FB_DATA !== 16'h0000) begin tests_failed++; $display("FAIL reset_fb_data: got %h expected 0000", FB_DATA); end
        tests_run++; if (FRAME_COUNT !== 16'd0) begin tests_failed++; $display("FAIL reset_frame_count: got %h expected 0000", FRAME_COUNT); end
        apply_reset();
    endtask

    task automatic test_basic_frame();
        bit to;
        apply_reset();
        pulse_start();
        wait_enables(6, to);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done(1, 1'b1, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL basic_timeout: frame did not complete, got done=%0d expected 1", done_cnt); end
        tests_run++; if (word_cnt !== 4) begin tests_failed++; $display("FAIL basic_word_count: got %0d expected 4", word_cnt); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (log_addr[i] !== 17'(i) || log_data[i] !== exp_word(i)) begin
                tests_failed++;
                $display("FAIL basic_word%0d: got addr %h data %h expected addr %h data %h", i, log_addr[i], log_data[i], 17'(i), exp_word(i));
            end
        end
        tests_run++; if (done_cnt !== 1 || done_bad !== 0) begin tests_failed++; $display("FAIL basic_frame_done: got %0d pulses (%0d long) expected 1 (0)", done_cnt, done_bad); end
        tests_run++; if (FRAME_COUNT !== 16'd1) begin tests_failed++; $display("FAIL basic_frame_count: got %0d expected 1", FRAME_COUNT); end
        tests_run++; if (RT_X !== 10'd0 || RT_Y !== 9'd0) begin tests_failed++; $display("FAIL basic_xy_end: got (%0d,%0d) expected (0,0)", RT_X, RT_Y); end
        tests_run++; if (coord_bad !== 0) begin tests_failed++; $display("FAIL basic_scan_order: got %0d bad coords expected 0", coord_bad); end
        repeat (20) @(negedge CLK);
        tests_run++; if (BUSY !== 1'b0 || enable_pulses !== 16) begin tests_failed++; $display("FAIL basic_idle_after: got busy %b enables %0d expected 0 and 16", BUSY, enable_pulses); end
    endtask

    task automatic test_stale_ready();
        bit to;
        apply_reset();
        busy_cycles = 5;
        pulse_start();
        wait_done(1, 1'b1, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL stale_timeout: got done=%0d expected 1", done_cnt); end
        tests_run++; if (enable_pulses !== 16) begin tests_failed++; $display("FAIL stale_enables: got %0d expected 16", enable_pulses); end
        tests_run++; if (rt_bad !== 0) begin tests_failed++; $display("FAIL stale_protocol: got %0d violations expected 0", rt_bad); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (log_data[i] !== exp_word(i)) begin
                tests_failed++;
                $display("FAIL stale_word%0d: got %h expected %h", i, log_data[i], exp_word(i));
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        apply_reset();
        stall_word = 2;
        stall_left = STALL;
        pulse_start();
        wait_done(1, 1'b1, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL bp_timeout: got done=%0d expected 1", done_cnt); end
        tests_run++; if (stall_seen !== STALL) begin tests_failed++; $display("FAIL bp_stall_cycles: got %0d expected %0d", stall_seen, STALL); end
        tests_run++; if (stall_bad !== 0) begin tests_failed++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stall_bad); end
        tests_run++; if (stall_addr !== 17'd2 || stall_data !== exp_word(2)) begin tests_failed++; $display("FAIL bp_held_word: got addr %h data %h expected 2 %h", stall_addr, stall_data, exp_word(2)); end
        tests_run++; if (word_cnt !== 4 || log_addr[3] !== 17'd3 || log_data[3] !== exp_word(3)) begin tests_failed++; $display("FAIL bp_after_stall: got %0d words last %h/%h expected 4 words 3/%h", word_cnt, log_addr[3], log_data[3], exp_word(3)); end
        tests_run++; if (enable_pulses !== 16) begin tests_failed++; $display("FAIL bp_enables: got %0d expected 16", enable_pulses); end
    endtask

    task automatic test_continuous();
        bit to;
        apply_reset();
        @(negedge CLK);
        CONTINUOUS = 1'b1;
        @(negedge CLK);
        expect_busy = 1'b1;
        wait_done(3, 1'b0, to);
        expect_busy = 1'b0;
        tests_run++; if (to) begin tests_failed++; $display("FAIL cont_timeout3: got done=%0d expected 3", done_cnt); end
        tests_run++; if (FRAME_COUNT !== 16'd3) begin tests_failed++; $display("FAIL cont_count3: got %0d expected 3", FRAME_COUNT); end
        tests_run++; if (busy_gap !== 0) begin tests_failed++; $display("FAIL cont_no_idle: got %0d idle cycles expected 0", busy_gap); end
        wait_enables(3*16 + 6, to);
        CONTINUOUS = 1'b0;
        wait_done(4, 1'b1, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL cont_timeout4: got done=%0d expected 4", done_cnt); end
        tests_run++; if (FRAME_COUNT !== 16'd4) begin tests_failed++; $display("FAIL cont_count4: got %0d expected 4", FRAME_COUNT); end
        tests_run++; if (enable_pulses !== 64 || word_cnt !== 16) begin tests_failed++; $display("FAIL cont_totals: got %0d enables %0d words expected 64 16", enable_pulses, word_cnt); end
        tests_run++; if (coord_bad !== 0 || rt_bad !== 0) begin tests_failed++; $display("FAIL cont_scan: got %0d coord %0d protocol errors expected 0", coord_bad, rt_bad); end
        tests_run++; if (log_addr[12] !== 17'd0 || log_data[15] !== exp_word(3)) begin tests_failed++; $display("FAIL cont_frame4_words: got addr %h data %h expected 0 %h", log_addr[12], log_data[15], exp_word(3)); end
        repeat (30) @(negedge CLK);
        tests_run++; if (BUSY !== 1'b0 || enable_pulses !== 64) begin tests_failed++; $display("FAIL cont_stays_idle: got busy %b enables %0d expected 0 64", BUSY, enable_pulses); end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit found;
        apply_reset();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            #1;
            if (RT_X == 10'd5 && RT_Y == 9'd1 && rt_busy && rt_cnt == 2) begin
                found = 1'b1;
                break;
            end
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL rstmid_reach: got no WAIT_DONE at (5,1) expected one"); end
        @(posedge CLK);
        #1 RESET_N = 1'b0;
        #1;
        tests_run++; if (RT_X !== 10'd0 || RT_Y !== 9'd0 || BUSY !== 1'b0) begin tests_failed++; $display("FAIL rstmid_state: got (%0d,%0d) busy %b expected (0,0) 0", RT_X, RT_Y, BUSY); end
        tests_run++; if (FB_ADDR !== 17'd0 || FB_DATA !== 16'h0 || FB_WE !== 1'b0) begin tests_failed++; $display("FAIL rstmid_fb: got addr %h data %h we %b expected 0 0 0", FB_ADDR, FB_DATA, FB_WE); end
        tests_run++; if (FRAME_COUNT !== 16'd0 || RT_ENABLE !== 1'b0) begin tests_failed++; $display("FAIL rstmid_count: got %0d en %b expected 0 0", FRAME_COUNT, RT_ENABLE); end
        @(negedge CLK);
        #2 RESET_N = 1'b1;
        clear_logs();
        pulse_start();
        wait_done(1, 1'b1, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL rstmid_timeout: got done=%0d expected 1", done_cnt); end
        tests_run++; if (word_cnt !== 4 || log_addr[0] !== 17'd0 || log_data[0] !== 16'h3210) begin tests_failed++; $display("FAIL rstmid_restart: got %0d words first %h/%h expected 4 0/3210", word_cnt, log_addr[0], log_data[0]); end
        tests_run++; if (coord_bad !== 0 || FRAME_COUNT !== 16'd1) begin tests_failed++; $display("FAIL rstmid_scan: got %0d bad coords count %0d expected 0 1", coord_bad, FRAME_COUNT); end
    endtask

    task automatic test_wrap();
        bit to;
        apply_reset();
        @(negedge CLK);
        force dut.frame_count_q = 16'hFFFF;
        @(negedge CLK);
        release dut.frame_count_q;
        #1;
        tests_run++; if (FRAME_COUNT !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_preload: got %h expected ffff", FRAME_COUNT); end
        pulse_start();
        wait_done(1, 1'b1, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL wrap_timeout: got done=%0d expected 1", done_cnt); end
        tests_run++; if (FRAME_COUNT !== 16'h0000) begin tests_failed++; $display("FAIL wrap_count: got %h expected 0000", FRAME_COUNT); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stale_ready();
        test_backpressure();
        test_continuous();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
